// File: rtl/ls_mem_unit.sv
// Memory-side half of the load/store unit: issues one op at a time on the
// 64-bit memory bus, waits for tagged load data, aligns/extends it, and completes.
module ls_mem_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rd_mem,
  input  logic             req_wr_mem,
  input  logic [2:0]       req_mem_size,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [4:0]       req_dest_reg_idx,
  output logic [1:0]       mem_command,
  output logic [XLEN-1:0]  mem_addr,
  output logic [1:0]       mem_size,
  output logic [63:0]      mem_wdata,
  input  logic [TAG_W-1:0] mem_response,
  input  logic [63:0]      mem_data,
  input  logic [TAG_W-1:0] mem_tag,
  output logic             done_valid,
  output logic [XLEN-1:0]  done_value,
  output logic [4:0]       done_dest_reg_idx,
  output logic             done_misaligned,
  output logic [2:0]       dbg_state
);

  // Handshake: a request is taken on a posedge where req_valid && req_ready;
  // req_ready is high exactly when the unit is IDLE and never looks at req_*.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, wdata_q, value_q;
  logic [2:0]        size_q;
  logic [4:0]        dest_q;
  logic              is_load_q, mis_q;
  logic [TAG_W-1:0]  tag_q;

  logic              op_go, mis_req, mem_accepted, tag_hit;
  logic [5:0]        lane_sh;
  logic [63:0]       lane, wd64;
  logic [XLEN-1:0]   load_val;

  assign op_go        = (state_q == S_IDLE) && req_valid && (req_rd_mem || req_wr_mem);
  assign mis_req      = ((req_mem_size[1:0] == 2'd1) && req_addr[0]) ||
                        ((req_mem_size[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
  assign mem_accepted = (state_q == S_ISSUE) && (mem_response != '0);
  assign tag_hit      = (mem_tag != '0) && (mem_tag == tag_q);
  assign lane_sh      = {addr_q[2:0], 3'b000};

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; squash outranks every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!squash && op_go) state_d = mis_req ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (squash)            state_d = (mem_accepted && is_load_q) ? S_DRAIN : S_IDLE;
        else if (mem_accepted) state_d = is_load_q ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (tag_hit)     state_d = squash ? S_IDLE : S_DONE;
        else if (squash) state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (tag_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    lane     = mem_data >> lane_sh;
    load_val = '0;
    case (size_q[1:0])
      2'd0:    load_val = {{(XLEN-8){lane[7] & ~size_q[2]}}, lane[7:0]};
      2'd1:    load_val = {{(XLEN-16){lane[15] & ~size_q[2]}}, lane[15:0]};
      default: load_val = lane[XLEN-1:0];
    endcase
  end

  // Operation latches
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      value_q   <= '0;
      size_q    <= '0;
      dest_q    <= '0;
      is_load_q <= 1'b0;
      mis_q     <= 1'b0;
      tag_q     <= '0;
    end else begin
      if (op_go && !squash) begin
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        value_q   <= '0;
        size_q    <= req_mem_size;
        dest_q    <= req_dest_reg_idx;
        is_load_q <= req_rd_mem;
        mis_q     <= mis_req;
      end
      if (mem_accepted && is_load_q) tag_q <= mem_response;
      if ((state_q == S_WAIT) && tag_hit) value_q <= load_val;
    end
  end

  // Outputs
  always_comb begin
    wd64                 = '0;
    wd64[XLEN-1:0]       = wdata_q;
    req_ready            = (state_q == S_IDLE);
    mem_command          = 2'd0;
    if (state_q == S_ISSUE) mem_command = is_load_q ? 2'd1 : 2'd2;
    mem_addr             = addr_q;
    mem_size             = size_q[1:0];
    mem_wdata            = wd64 << lane_sh;
    done_valid           = (state_q == S_DONE) && !squash;
    done_value           = done_valid ? value_q : '0;
    done_dest_reg_idx    = done_valid ? dest_q : 5'd0;
    done_misaligned      = done_valid & mis_q;
    dbg_state            = state_q;
  end

endmodule

// File: tb/tb_ls_mem_unit.sv
// Directed and randomized bench for ls_mem_unit; the bench plays the memory
// and predicts bus traffic and completions from an arithmetic reference model.
module tb_ls_mem_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset, squash, req_valid, req_ready, req_rd_mem, req_wr_mem;
  logic [2:0]       req_mem_size;
  logic [XLEN-1:0]  req_addr, req_wdata;
  logic [4:0]       req_dest_reg_idx;
  logic [1:0]       mem_command, mem_size;
  logic [XLEN-1:0]  mem_addr;
  logic [63:0]      mem_wdata, mem_data;
  logic [TAG_W-1:0] mem_response, mem_tag;
  logic             done_valid, done_misaligned;
  logic [XLEN-1:0]  done_value;
  logic [4:0]       done_dest_reg_idx;
  logic [2:0]       dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  ls_mem_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_mem(req_rd_mem), .req_wr_mem(req_wr_mem),
    .req_mem_size(req_mem_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_dest_reg_idx(req_dest_reg_idx),
    .mem_command(mem_command), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_response(mem_response), .mem_data(mem_data),
    .mem_tag(mem_tag), .done_valid(done_valid), .done_value(done_value),
    .done_dest_reg_idx(done_dest_reg_idx), .done_misaligned(done_misaligned),
    .dbg_state(dbg_state)
  );

  // Clock/reset
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Reference model
  function automatic logic ref_misaligned(input logic [31:0] a, input logic [2:0] sz);
    return ((sz[1:0] == 2'd1) && (a % 2 != 0)) || ((sz[1:0] == 2'd2) && (a % 4 != 0));
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [31:0] w, input logic [31:0] a);
    logic [63:0] scale;
    scale = 64'd1 << (8 * (a % 8));
    return {32'd0, w} * scale;
  endfunction

  function automatic logic [31:0] ref_load(input logic [63:0] d, input logic [31:0] a,
                                           input logic [2:0] sz);
    longint unsigned lane;
    longint v;
    int nbytes;
    lane   = d >> (8 * (a % 8));
    nbytes = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    v      = longint'(lane % (64'd1 << (8 * nbytes)));
    if (nbytes < 4 && !sz[2] && v >= (longint'(1) << (8 * nbytes - 1)))
      v = v - (longint'(1) << (8 * nbytes));
    return v[31:0];
  endfunction

  // Driver tasks
  task automatic send(input logic rd, input logic wr, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dest);
    req_valid = 1'b1; req_rd_mem = rd; req_wr_mem = wr; req_mem_size = sz;
    req_addr = addr; req_wdata = wdata; req_dest_reg_idx = dest;
    #1 chk("ready_at_accept", req_ready, 1);
    cyc();
    req_valid = 1'b0; req_rd_mem = 1'b0; req_wr_mem = 1'b0;
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dest,
                        input int nretry, input logic [3:0] tag, input int lat,
                        input logic [63:0] data);
    logic [3:0] stray;
    send(rd, wr, sz, addr, wdata, dest);
    #1;
    if (!rd && !wr) begin
      chk("drop_ready", req_ready, 1);
      chk("drop_cmd", mem_command, 0);
      chk("drop_done", done_valid, 0);
      return;
    end
    if (ref_misaligned(addr, sz)) begin
      chk("mis_cmd", mem_command, 0);
      chk("mis_done", done_valid, 1);
      chk("mis_flag", done_misaligned, 1);
      chk("mis_value", done_value, 0);
      chk("mis_dest", done_dest_reg_idx, dest);
      cyc(); #1;
      chk("mis_after_done", done_valid, 0);
      chk("mis_after_ready", req_ready, 1);
      return;
    end
    for (int i = 0; i <= nretry; i++) begin
      chk("issue_cmd", mem_command, rd ? 2'd1 : 2'd2);
      chk("issue_addr", mem_addr, addr);
      chk("issue_size", mem_size, sz[1:0]);
      if (!rd) chk("issue_wdata", mem_wdata, ref_wdata(wdata, addr));
      chk("issue_busy", req_ready, 0);
      mem_response = (i == nretry) ? tag : 4'd0;
      cyc();
      mem_response = '0;
      #1;
    end
    if (!rd) exp_q.push_back('0);
    else begin
      for (int j = 0; j < lat; j++) begin
        chk("wait_cmd", mem_command, 0);
        chk("wait_done", done_valid, 0);
        if (j == lat - 1) begin
          mem_tag = tag; mem_data = data;
        end else begin
          stray = 4'($urandom_range(0, 15));
          if (stray == tag) stray = 4'd0;
          mem_tag = stray; mem_data = {$urandom, $urandom};
        end
        cyc();
        mem_tag = '0;
        #1;
      end
      exp_q.push_back(ref_load(data, addr, sz));
    end
    chk("done_valid", done_valid, 1);
    chk("done_value", done_value, exp_q.pop_front());
    chk("done_dest", done_dest_reg_idx, dest);
    chk("done_mis", done_misaligned, 0);
    cyc(); #1;
    chk("after_done_valid", done_valid, 0);
    chk("after_done_ready", req_ready, 1);
  endtask

  initial begin
    reset = 1'b0; squash = 1'b0; req_valid = 1'b0; req_rd_mem = 1'b0; req_wr_mem = 1'b0;
    req_mem_size = '0; req_addr = '0; req_wdata = '0; req_dest_reg_idx = '0;
    mem_response = '0; mem_data = '0; mem_tag = '0;
    repeat (2) cyc();
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_cmd", mem_command, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_size", mem_size, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_value", done_value, 0);
    chk("rst_dest", done_dest_reg_idx, 0);
    chk("rst_mis", done_misaligned, 0);
    reset = 1'b1;
    cyc();

    // Signed/unsigned byte load, store word, retry with stray tags
    run_op(1, 0, 3'd0, 32'h1005, 0, 5'd1, 0, 4'd3, 3, 64'h0000_8000_0000_0000);
    run_op(1, 0, 3'd4, 32'h1005, 0, 5'd2, 0, 4'd3, 3, 64'h0000_8000_0000_0000);
    run_op(0, 1, 3'd2, 32'h2004, 32'hDEADBEEF, 5'd3, 0, 4'd1, 0, 64'd0);
    run_op(1, 0, 3'd2, 32'h2000, 0, 5'd4, 3, 4'd7, 4, 64'h1234_5678_9ABC_DEF0);
    // Misaligned, dropped, and load-precedence ops
    run_op(1, 0, 3'd1, 32'h3001, 0, 5'd5, 0, 4'd1, 1, 64'd0);
    run_op(0, 1, 3'd2, 32'h3002, 32'h55, 5'd6, 0, 4'd1, 1, 64'd0);
    run_op(0, 0, 3'd2, 32'h3000, 0, 5'd7, 0, 4'd1, 1, 64'd0);
    run_op(1, 1, 3'd1, 32'h4006, 0, 5'd8, 1, 4'd9, 2, 64'hFFEE_0000_0000_0000);

    // Squash in WAIT -> DRAIN, squash in DRAIN ignored
    send(1, 0, 3'd2, 32'h40, 0, 5'd9);
    #1 mem_response = 4'd2;
    cyc(); mem_response = '0;
    squash = 1'b1;
    cyc(); squash = 1'b0;
    #1 chk("drain_ready", req_ready, 0);
    chk("drain_done", done_valid, 0);
    mem_tag = 4'd5; squash = 1'b1;
    cyc(); mem_tag = '0; squash = 1'b0;
    #1 chk("drain_hold_ready", req_ready, 0);
    mem_tag = 4'd2; mem_data = 64'hFF;
    cyc(); mem_tag = '0;
    #1 chk("drain_exit_ready", req_ready, 1);
    chk("drain_exit_done", done_valid, 0);
    run_op(1, 0, 3'd0, 32'h41, 0, 5'd10, 0, 4'd2, 1, 64'h0000_0000_0000_7F00);

    // Squash in DONE suppresses the completion
    send(0, 1, 3'd2, 32'h50, 32'h1, 5'd11);
    #1 mem_response = 4'd1;
    cyc(); mem_response = '0; squash = 1'b1;
    #1 chk("sq_done_valid", done_valid, 0);
    chk("sq_done_value", done_value, 0);
    cyc(); squash = 1'b0;
    #1 chk("sq_done_ready", req_ready, 1);

    // Squash with a same-cycle tag match goes straight to IDLE
    send(1, 0, 3'd2, 32'h60, 0, 5'd12);
    #1 mem_response = 4'd4;
    cyc(); mem_response = '0; mem_tag = 4'd4; squash = 1'b1;
    cyc(); mem_tag = '0; squash = 1'b0;
    #1 chk("sq_hit_ready", req_ready, 1);
    chk("sq_hit_done", done_valid, 0);

    // Squash in ISSUE: accepted load drains, accepted store and no-accept go idle
    send(1, 0, 3'd2, 32'h70, 0, 5'd13);
    #1 mem_response = 4'd6; squash = 1'b1;
    cyc(); mem_response = '0; squash = 1'b0;
    #1 chk("sq_issue_ld_ready", req_ready, 0);
    mem_tag = 4'd6;
    cyc(); mem_tag = '0;
    #1 chk("sq_issue_ld_exit", req_ready, 1);
    chk("sq_issue_ld_done", done_valid, 0);
    send(0, 1, 3'd2, 32'h74, 32'h2, 5'd14);
    #1 mem_response = 4'd6; squash = 1'b1;
    cyc(); mem_response = '0; squash = 1'b0;
    #1 chk("sq_issue_st_ready", req_ready, 1);
    chk("sq_issue_st_done", done_valid, 0);
    send(1, 0, 3'd2, 32'h78, 0, 5'd15);
    #1 squash = 1'b1;
    cyc(); squash = 1'b0;
    #1 chk("sq_issue_none_ready", req_ready, 1);

    // Squash in IDLE drops the accept
    req_valid = 1'b1; req_rd_mem = 1'b1; squash = 1'b1; req_addr = 32'h80; req_mem_size = 3'd2;
    cyc(); req_valid = 1'b0; req_rd_mem = 1'b0; squash = 1'b0;
    #1 chk("sq_idle_ready", req_ready, 1);
    chk("sq_idle_cmd", mem_command, 0);

    // Reset in WAIT
    send(1, 0, 3'd2, 32'h90, 0, 5'd16);
    #1 mem_response = 4'd9;
    cyc(); mem_response = '0; reset = 1'b0;
    cyc(); reset = 1'b1;
    #1 chk("rst_wait_ready", req_ready, 1);
    chk("rst_wait_cmd", mem_command, 0);
    chk("rst_wait_done", done_valid, 0);
    chk("rst_wait_addr", mem_addr, 0);

    // Randomized ops
    for (int k = 0; k < 60; k++) begin
      int r;
      logic rd, wr;
      logic [2:0] sz;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      rd = (r == 1) || (r >= 2 && r < 6);
      wr = (r == 1) || (r >= 6);
      case ($urandom_range(0, 4))
        0: sz = 3'd0;
        1: sz = 3'd1;
        2: sz = 3'd2;
        3: sz = 3'd4;
        default: sz = 3'd5;
      endcase
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'd3;
      run_op(rd, wr, sz, a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 2),
             4'($urandom_range(1, 15)), $urandom_range(1, 4), {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ls_mem_unit.md
# ls_mem_unit

Memory-side partner of the load/store functional unit. It accepts one resolved memory op per transaction: effective address, store data, size and destination tag. It drives the single-ported 64-bit processor-to-memory bus, tracks the response tag of an outstanding load, and aligns and extends returned data. It then emits a one-cycle completion toward the CDB/ROB. One op is in flight at a time; squash-safe, including draining an orphaned load response.

## Interface
- XLEN, 32, datapath/address width
- TAG_W, 4, memory transaction tag width; tag 0 means "no tag / rejected"

- clock  in  1  system clock
- reset  in  1  synchronous, active-low; reset==0 at posedge resets
- squash  in  1  pipeline flush
- req_valid  in  1  FU result valid this cycle
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready
- req_rd_mem  in  1  op is a load
- req_wr_mem  in  1  op is a store
- req_mem_size  in  3  funct3: [1:0] 0=byte, 1=half, 2=word; [2] 1=unsigned load
- req_addr  in  XLEN  effective byte address
- req_wdata  in  XLEN  store data (rs2 value)
- req_dest_reg_idx  in  5  destination register
- mem_command  out  2  0=NONE, 1=LOAD, 2=STORE
- mem_addr  out  XLEN  latched byte address
- mem_size  out  2  latched req_mem_size[1:0]
- mem_wdata  out  64  store data shifted left by 8*addr[2:0]
- mem_response  in  TAG_W  nonzero = request accepted with this tag
- mem_data  in  64  returned doubleword
- mem_tag  in  TAG_W  tag of mem_data; 0 = nothing returning
- done_valid  out  1  completion pulse
- done_value  out  XLEN  extended load data; 0 for stores/exceptions
- done_dest_reg_idx  out  5  latched destination
- done_misaligned  out  1  misaligned access exception

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN. req_ready = (state==IDLE). mem_command is nonzero only in ISSUE.
- IDLE, accept with rd_mem or wr_mem set:
  - Latch address, size, wdata and dest.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. A misaligned op goes to DONE with done_misaligned=1 and no bus request.
  - Otherwise go to ISSUE.
- IDLE, accept with neither rd_mem nor wr_mem: drop the op; no done. If both are set, the load takes precedence.
- ISSUE: drive LOAD/STORE.
  - mem_response==0: stay and retry next cycle with identical outputs.
  - Nonzero response on a store: go to DONE.
  - Nonzero response on a load: latch the tag and go to WAIT.
- WAIT: command NONE. When mem_tag==latched tag (and is nonzero), go to DONE with extracted data. Any other tag is ignored.
- Load extraction: lane = mem_data >> 8*addr[2:0]. Take byte/half/word from that lane. Sign-extend unless size[2]=1; word ignores size[2].
- DONE: done_valid=1 for exactly one cycle, then IDLE. done_* outputs hold their latched values only while done_valid=1 and are 0 otherwise.
- Squash, priority over all other transitions:
  - IDLE, ISSUE with no accept, or DONE: go to IDLE. Suppress done_valid in that cycle and drop any accept.
  - WAIT, or ISSUE whose load is accepted the same cycle: go to DRAIN, keeping the tag.
  - ISSUE whose store is accepted the same cycle: the store is performed; go to IDLE with no done.
- DRAIN: req_ready=0. Wait for mem_tag==saved tag, then go to IDLE with no done. Further squashes are ignored.
- Reset (synchronous, reset==0): state IDLE, all latches 0. Outputs after reset: req_ready=1, mem_command=0, mem_addr=0, mem_size=0, mem_wdata=0, done_*=0.

## Timing
- Accept at cycle T; ISSUE drives the bus at T+1.
- Store, accepted by memory at T+1: done_valid at T+2.
- Load with tag returned at cycle R: done_valid at R+1. Minimum accept-to-done is 3 cycles.
- Misaligned op: done at T+1.
- Every done adds one IDLE cycle before the next accept. Back-to-back throughput: store every 3 cycles, misaligned op every 2 cycles.
- The tag compare in WAIT is combinational on mem_tag. A tag matching in the same cycle as a squash is consumed by the squash: go to IDLE, not DRAIN.
- All state changes occur on posedge clock. No combinational path from req_* to mem_*. req_ready depends on state only.

## Test plan
- Signed byte load: addr=0x1005, size=0, response=3 at T+1, tag=3 at T+4 with mem_data byte5=0x80 -> done_valid at T+5, done_value=0xFFFFFF80. Repeat with size=4 -> 0x00000080.
- Store word: addr=0x2004, wdata=0xDEADBEEF -> mem_command=2, mem_wdata=0xDEADBEEF_00000000, mem_size=2. Done at T+2 with value 0.
- Retry: mem_response=0 for 3 cycles, then 7 -> LOAD held with constant addr for 4 cycles; unit enters WAIT with tag 7. Stray tag 5 in WAIT is ignored.
- Misaligned: half at 0x3001 -> no bus command; done_misaligned=1 at T+1.
- Squash in WAIT (tag 2): req_ready=0 until mem_tag=2, then IDLE with no done. A new load then completes normally.
- Reset (reset=0) asserted in WAIT -> the next cycle shows req_ready=1, mem_command=0 and done_valid=0.
